altmemddr_ex_rd_compare: RTL and testbench
==========================================

Name: altmemddr_ex_rd_compare

Overview:
Downstream read-data checker for the altmemddr example traffic driver. It consumes read data returned by the memory controller and regenerates the expected per-byte pseudo-random pattern that was written. Each byte lane is compared against its own 8-bit LFSR, and the block reports per-byte, aggregate and persistent pass/not-fail (pnf) status to the example top level.

Parameters:
DWIDTH, 32, local read data width in bits; multiple of 8
SEED, 32, base LFSR seed; lane i seed = (SEED + i) mod 256
CNT_W, 16, error counter width; used only with the optional feature

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  0 holds all lane LFSRs at seed and the FSM in IDLE
start  in  1  1-cycle pulse; reseeds lanes, clears sticky status, enters CHECK
rdata_valid  in  1  rdata qualifier
rdata  in  DWIDTH  read data from controller
last_burst  in  1  qualifies rdata_valid as the final beat of the test
pnf_per_byte  out  DWIDTH/8  1 = lane matched on the last compared beat
pnf  out  1  AND of pnf_per_byte
pnf_persist  out  1  sticky; 0 once any lane mismatches since start
compare_done  out  1  high in DONE
error_count  out  CNT_W  mismatching beats; present only with the optional feature

Behaviour:
- Reset values: pnf_per_byte all 1, pnf 1, pnf_persist 1, compare_done 0, error_count 0, FSM IDLE, lane i LFSR = SEED+i.
- LFSR step for state q: next[0]=q[7], next[1]=q[0], next[2]=q[1]^q[7], next[3]=q[2]^q[7], next[4]=q[3]^q[7], next[5]=q[4], next[6]=q[5], next[7]=q[6].
- All lane LFSRs step together, once per accepted beat: rdata_valid=1 in CHECK.
- FSM states:
  - IDLE -> CHECK on start.
  - CHECK -> DONE on an accepted beat with last_burst=1.
  - DONE -> CHECK on start.
  - Any state -> IDLE when enable=0.
- start: lanes reload seeds; pnf_persist=1 and pnf_per_byte all 1 on the next cycle; error_count=0. A beat arriving in the start cycle is ignored.
- Compare: byte i of rdata (bits 8i+7:8i) is compared with lane i LFSR state before the step. Outputs are registered, so there is 1-cycle latency from the accepted beat to pnf_per_byte, pnf and pnf_persist.
- Beats with rdata_valid=0, or received in IDLE or DONE, are ignored. Outputs hold and LFSRs hold.
- pnf_persist only falls inside CHECK. It recovers only by start or reset.
- compare_done is asserted in the cycle after the last beat is accepted, and the final compare result is valid in that same cycle.
- enable=0 mid-test: return to IDLE the next cycle, compare_done=0, status outputs hold.
- reset_n asserted mid-test: all state returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN.
- Defined: error_count increments by 1 per accepted beat with any lane mismatch. It saturates at all-ones, does not wrap, and clears on start or reset.
- Undefined: no error_count port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package altmemddr_ex_pkg holds:
  - FSM state encoding (IDLE=2'd0, CHECK=2'd1, DONE=2'd2)
  - function lfsr8_next(q) implementing the step above
  - constant LFSR_W=8
- One natural sub-module: altmemddr_ex_exp_lane, a per-lane expected-byte generator with parameter LANE_SEED and ports clk, reset_n, enable, reseed, step, exp[7:0]. It is instantiated DWIDTH/8 times via generate.

Test Plan:
- Reset then start; feed lane-0 bytes 0x20, 0x40, 0x80, 0x1D and lane-1 bytes 0x21, 0x42, ... -> pnf_per_byte=4'hF every beat, pnf_persist=1.
- Corrupt byte 2 of the 2nd beat (expected 0x44, send 0x45) -> one cycle later pnf_per_byte=4'b1011, pnf=0. pnf_persist=0 and stays 0 through later correct beats. error_count=1 with the feature.
- Drive rdata_valid low for 5 cycles mid-stream, then resume with the correct next value -> no mismatch; LFSRs did not advance during the gap.
- last_burst on the 4th beat -> compare_done=1 from the next cycle. Extra valid beats are ignored. start clears compare_done and pnf_persist returns to 1.
- Drop enable mid-test, raise it again, then start -> lanes restart from 0x20/0x21/0x22/0x23 and the correct sequence passes.
- Assert reset_n low mid-CHECK -> outputs are at reset values immediately, without waiting for a clock edge. With the feature, force 2^CNT_W+3 bad beats -> error_count saturates at all-ones.

Source files
------------

// File: rtl/altmemddr_ex_pkg.sv
// ---------------------------------------------------------------------------
// altmemddr_ex_pkg
// Shared definitions for the altmemddr example read-data checker:
//   - LFSR_W      : width of one byte-lane pattern generator
//   - state_t     : checker FSM encoding (IDLE/CHECK/DONE)
//   - lfsr8_next  : one step of the per-lane 8-bit pattern LFSR
// ---------------------------------------------------------------------------
package altmemddr_ex_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Galois-style step: shift left, feeding q[7] back into taps 0, 2, 3, 4.
    function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] n;
        n[0] = q[7];
        n[1] = q[0];
        n[2] = q[1] ^ q[7];
        n[3] = q[2] ^ q[7];
        n[4] = q[3] ^ q[7];
        n[5] = q[4];
        n[6] = q[5];
        n[7] = q[6];
        return n;
    endfunction

endpackage

// File: rtl/altmemddr_ex_exp_lane.sv
// ---------------------------------------------------------------------------
// altmemddr_ex_exp_lane
// Expected-byte generator for one read-data byte lane.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset (loads LANE_SEED)
//   enable   in   0 holds the lane at LANE_SEED
//   reseed   in   1 reloads LANE_SEED
//   step     in   1 advances the LFSR by one state
//   exp      out  expected byte for the current beat (pre-step state)
// ---------------------------------------------------------------------------
module altmemddr_ex_exp_lane
    import altmemddr_ex_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LANE_SEED = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              reseed,
    input  logic              step,
    output logic [LFSR_W-1:0] exp
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= LANE_SEED;
        end else if (!enable || reseed) begin
            r_q <= LANE_SEED;
        end else if (step) begin
            r_q <= lfsr8_next(r_q);
        end
    end

    assign exp = r_q;

endmodule

// File: rtl/altmemddr_ex_rd_compare.sv
// ---------------------------------------------------------------------------
// altmemddr_ex_rd_compare
// Read-data checker for the altmemddr example traffic driver. Each byte lane
// of rdata is compared against its own 8-bit LFSR pattern; per-byte,
// aggregate and sticky pass/not-fail status are registered outputs.
// Optional feature macro: ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
//   adds a saturating error_count of mismatching beats.
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   0 forces IDLE and holds lanes at seed
//   start         in   pulse: reseed lanes, clear sticky status, enter CHECK
//   rdata_valid   in   rdata qualifier
//   rdata         in   read data, DWIDTH bits
//   last_burst    in   marks the final beat of the test
//   pnf_per_byte  out  1 per lane that matched on the last compared beat
//   pnf           out  AND of pnf_per_byte
//   pnf_persist   out  sticky pass flag since start
//   compare_done  out  high in DONE
//   error_count   out  mismatching-beat count (optional feature only)
// ---------------------------------------------------------------------------
module altmemddr_ex_rd_compare
    import altmemddr_ex_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int SEED   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                start,
    input  logic                rdata_valid,
    input  logic [DWIDTH-1:0]   rdata,
    input  logic                last_burst,
    output logic [DWIDTH/8-1:0] pnf_per_byte,
    output logic                pnf,
    output logic                pnf_persist,
    output logic                compare_done
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]    error_count
`endif
);

    localparam int LANES = DWIDTH / 8;

    if ((DWIDTH % 8) != 0 || DWIDTH < 8 || CNT_W < 1) begin : g_cfg_err
        $error("altmemddr_ex_rd_compare: DWIDTH must be a multiple of 8 and CNT_W >= 1");
    end

    state_t              r_state;
    logic [LANES-1:0]    r_pnf_per_byte;
    logic                r_pnf;
    logic                r_pnf_persist;
    logic                r_compare_done;

    logic [LFSR_W-1:0]   w_exp [LANES];
    logic [LANES-1:0]    w_match;
    logic                w_accept;
    logic                w_all_match;

    // A beat coinciding with start is dropped: the lanes are being reseeded.
    assign w_accept    = enable && !start && rdata_valid && (r_state == ST_CHECK);
    assign w_all_match = &w_match;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [LFSR_W-1:0] LS = LFSR_W'((SEED + gi) % 256);

        altmemddr_ex_exp_lane #(
            .LANE_SEED (LS)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable),
            .reseed  (start),
            .step    (w_accept),
            .exp     (w_exp[gi])
        );

        assign w_match[gi] = (rdata[8*gi +: 8] == w_exp[gi]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_pnf_per_byte <= '1;
            r_pnf          <= 1'b1;
            r_pnf_persist  <= 1'b1;
            r_compare_done <= 1'b0;
        end else if (!enable) begin
            // Status outputs intentionally hold across a disable.
            r_state        <= ST_IDLE;
            r_compare_done <= 1'b0;
        end else if (start) begin
            r_state        <= ST_CHECK;
            r_pnf_per_byte <= '1;
            r_pnf          <= 1'b1;
            r_pnf_persist  <= 1'b1;
            r_compare_done <= 1'b0;
        end else if (w_accept) begin
            r_pnf_per_byte <= w_match;
            r_pnf          <= w_all_match;
            r_pnf_persist  <= r_pnf_persist & w_all_match;
            if (last_burst) begin
                r_state        <= ST_DONE;
                r_compare_done <= 1'b1;
            end
        end
    end

    assign pnf_per_byte = r_pnf_per_byte;
    assign pnf          = r_pnf;
    assign pnf_persist  = r_pnf_persist;
    assign compare_done = r_compare_done;

`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating count of accepted beats with at least one bad lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (enable && start) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_all_match && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign error_count = r_err_cnt;
`else
    // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_altmemddr_ex_rd_compare.sv
// ---------------------------------------------------------------------------
// tb_altmemddr_ex_rd_compare
// Directed bench for altmemddr_ex_rd_compare (DWIDTH=32, SEED=32).
// Expected lane patterns below were worked out by hand from the LFSR step
// (shift left, xor 0x1D when bit 7 was set), lanes seeded 0x20..0x23.
// Status word compared: {pnf_per_byte[3:0], pnf, pnf_persist, compare_done}.
// Define ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN to exercise error_count.
// ---------------------------------------------------------------------------
module tb_altmemddr_ex_rd_compare;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        rdata_valid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        last_burst = 1'b0;
    logic [3:0]  pnf_per_byte;
    logic        pnf;
    logic        pnf_persist;
    logic        compare_done;
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
    logic [15:0] error_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [6:0] st;
    assign st = {pnf_per_byte, pnf, pnf_persist, compare_done};

    // Beats: {lane3, lane2, lane1, lane0}
    logic [31:0] good [0:7] = '{
        32'h23222120, 32'h46444240, 32'h8C888480, 32'h050D151D,
        32'h0A1A2A3A, 32'h14345474, 32'h2868A8E8, 32'h50D04DCD
    };

    always #5 clk = ~clk;

    altmemddr_ex_rd_compare #(
        .DWIDTH (32),
        .SEED   (32),
        .CNT_W  (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .start        (start),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .last_burst   (last_burst),
        .pnf_per_byte (pnf_per_byte),
        .pnf          (pnf),
        .pnf_persist  (pnf_persist),
        .compare_done (compare_done)
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        ,
        .error_count  (error_count)
`endif
    );

    // One accepted-or-not beat; returns 1 ns after the capturing edge.
    task automatic beat(input logic [31:0] d, input logic lst);
        rdata_valid = 1'b1;
        rdata       = d;
        last_burst  = lst;
        @(posedge clk);
        #1;
        rdata_valid = 1'b0;
        last_burst  = 1'b0;
    endtask

    task automatic do_start(input logic v, input logic [31:0] d);
        start       = 1'b1;
        rdata_valid = v;
        rdata       = d;
        @(posedge clk);
        #1;
        start       = 1'b0;
        rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL reset_async: status=%b expected %b", st, 7'b1111_110);
        end
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        n_vec++;
        if (error_count !== 16'h0) begin
            n_miss++;
            $display("FAIL reset_cnt: error_count=%h expected 0000", error_count);
        end
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL reset_release: status=%b expected %b", st, 7'b1111_110);
        end
        $display("test_reset: status=%b", st);
    endtask

    task automatic test_pass();
        do_start(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            beat(good[i], 1'b0);
            n_vec++;
            if (st !== 7'b1111_110) begin
                n_miss++;
                $display("FAIL pass_beat%0d: status=%b expected %b", i, st, 7'b1111_110);
            end
            $display("test_pass: beat %0d data=%h status=%b", i, good[i], st);
        end
    endtask

    task automatic test_corrupt();
        logic [31:0] d [0:3];
        logic [6:0]  e [0:3];
        d = '{good[0], 32'h46454240, good[2], good[3]};
        e = '{7'b1111_110, 7'b1011_000, 7'b1111_100, 7'b1111_100};
        do_start(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            beat(d[i], 1'b0);
            n_vec++;
            if (st !== e[i]) begin
                n_miss++;
                $display("FAIL corrupt_beat%0d: status=%b expected %b", i, st, e[i]);
            end
            $display("test_corrupt: beat %0d data=%h status=%b", i, d[i], st);
        end
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        n_vec++;
        if (error_count !== 16'd1) begin
            n_miss++;
            $display("FAIL corrupt_cnt: error_count=%0d expected 1", error_count);
        end
`endif
    endtask

    task automatic test_gap();
        do_start(1'b0, 32'h0);
        beat(good[0], 1'b0);
        beat(good[1], 1'b0);
        // Garbage on the bus with valid low must not be compared.
        rdata = 32'hDEADBEEF;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL gap_hold: status=%b expected %b", st, 7'b1111_110);
        end
        for (int i = 2; i < 4; i++) begin
            beat(good[i], 1'b0);
            n_vec++;
            if (st !== 7'b1111_110) begin
                n_miss++;
                $display("FAIL gap_resume%0d: status=%b expected %b", i, st, 7'b1111_110);
            end
            $display("test_gap: beat %0d data=%h status=%b", i, good[i], st);
        end
    endtask

    task automatic test_done();
        // Beat in the start cycle carries garbage and must be ignored.
        do_start(1'b1, 32'hFFFFFFFF);
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL done_start: status=%b expected %b", st, 7'b1111_110);
        end
        beat(good[0], 1'b0);
        beat(32'h46444241, 1'b0);
        n_vec++;
        if (st !== 7'b1110_000) begin
            n_miss++;
            $display("FAIL done_bad_lane0: status=%b expected %b", st, 7'b1110_000);
        end
        beat(good[2], 1'b0);
        beat(good[3], 1'b1);
        n_vec++;
        if (st !== 7'b1111_101) begin
            n_miss++;
            $display("FAIL done_last: status=%b expected %b", st, 7'b1111_101);
        end
        $display("test_done: last beat status=%b", st);
        beat(32'h00000000, 1'b0);
        n_vec++;
        if (st !== 7'b1111_101) begin
            n_miss++;
            $display("FAIL done_extra: status=%b expected %b", st, 7'b1111_101);
        end
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        n_vec++;
        if (error_count !== 16'd1) begin
            n_miss++;
            $display("FAIL done_cnt: error_count=%0d expected 1", error_count);
        end
`endif
        do_start(1'b0, 32'h0);
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL done_restart: status=%b expected %b", st, 7'b1111_110);
        end
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        n_vec++;
        if (error_count !== 16'd0) begin
            n_miss++;
            $display("FAIL done_cnt_clr: error_count=%0d expected 0", error_count);
        end
`endif
        beat(good[0], 1'b0);
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL done_reseed: status=%b expected %b", st, 7'b1111_110);
        end
        $display("test_done: after restart status=%b", st);
    endtask

    task automatic test_enable();
        do_start(1'b0, 32'h0);
        beat(good[0], 1'b0);
        beat(32'h46454240, 1'b0);
        beat(good[2], 1'b0);
        beat(good[3], 1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (st !== 7'b1111_100) begin
            n_miss++;
            $display("FAIL enable_drop: status=%b expected %b", st, 7'b1111_100);
        end
        enable = 1'b1;
        // Now in IDLE: a valid beat must be ignored.
        beat(32'h00000000, 1'b0);
        n_vec++;
        if (st !== 7'b1111_100) begin
            n_miss++;
            $display("FAIL enable_idle_beat: status=%b expected %b", st, 7'b1111_100);
        end
        do_start(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            beat(good[i], (i == 3));
            n_vec++;
            if (st !== ((i == 3) ? 7'b1111_111 : 7'b1111_110)) begin
                n_miss++;
                $display("FAIL enable_rerun%0d: status=%b expected %b", i, st,
                         ((i == 3) ? 7'b1111_111 : 7'b1111_110));
            end
            $display("test_enable: beat %0d data=%h status=%b", i, good[i], st);
        end
    endtask

    task automatic test_async_reset();
        do_start(1'b0, 32'h0);
        beat(good[0], 1'b0);
        beat(32'h46454240, 1'b0);
        reset_n = 1'b0;
        #2;
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL async_reset: status=%b expected %b", st, 7'b1111_110);
        end
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        n_vec++;
        if (error_count !== 16'd0) begin
            n_miss++;
            $display("FAIL async_reset_cnt: error_count=%0d expected 0", error_count);
        end
`endif
        @(posedge clk);
        #1 reset_n = 1'b1;
        // Without start the FSM is IDLE: this beat must be ignored.
        beat(32'h00000000, 1'b0);
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL async_idle: status=%b expected %b", st, 7'b1111_110);
        end
        do_start(1'b0, 32'h0);
        beat(good[0], 1'b0);
        n_vec++;
        if (st !== 7'b1111_110) begin
            n_miss++;
            $display("FAIL async_rerun: status=%b expected %b", st, 7'b1111_110);
        end
        $display("test_async_reset: status=%b", st);
    endtask

`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
    task automatic test_err_sat();
        do_start(1'b0, 32'h0);
        // All-zero data never matches a nonzero LFSR state.
        for (int i = 0; i < 3; i++) beat(32'h00000000, 1'b0);
        n_vec++;
        if (error_count !== 16'd3) begin
            n_miss++;
            $display("FAIL sat_early: error_count=%0d expected 3", error_count);
        end
        for (int i = 3; i < 65536 + 3; i++) beat(32'h00000000, 1'b0);
        n_vec++;
        if (error_count !== 16'hFFFF) begin
            n_miss++;
            $display("FAIL sat_final: error_count=%h expected ffff", error_count);
        end
        $display("test_err_sat: error_count=%h", error_count);
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_corrupt();
        test_gap();
        test_done();
        test_enable();
        test_async_reset();
`ifdef ALTMEMDDR_EX_RD_COMPARE_ERR_CNT_EN
        test_err_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
